// File: rtl/tag_inventory_ctrl_if.sv
// Parser/RNG-facing inputs and TX-facing results of the Gen2 tag inventory controller.
interface tag_inventory_ctrl_if #(
  parameter int SLOT_W  = 15,
  parameter int NUM_CMD = 13
);
  logic [NUM_CMD-1:0] cmd;
  logic               packet_complete;
  logic               crc5invalid;
  logic               crc16invalid;
  logic [3:0]         q_in;
  logic [2:0]         updn;
  logic [15:0]        rn_in;
  logic               rn_match;
  logic               select_match;

  logic               rng_next;
  logic [2:0]         state;
  logic [3:0]         q_cur;
  logic [SLOT_W-1:0]  slot;
  logic [15:0]        rn16;
  logic [15:0]        handle;
  logic               reply_go;
  logic [2:0]         reply_type;
  logic               sensor_go;
  logic               inv_flag;
  logic               sel_flag;
  logic               crc_err;

  modport master (
    output cmd, packet_complete, crc5invalid, crc16invalid, q_in, updn, rn_in, rn_match, select_match,
    input  rng_next, state, q_cur, slot, rn16, handle, reply_go, reply_type, sensor_go, inv_flag, sel_flag, crc_err
  );
  modport slave (
    input  cmd, packet_complete, crc5invalid, crc16invalid, q_in, updn, rn_in, rn_match, select_match,
    output rng_next, state, q_cur, slot, rn16, handle, reply_go, reply_type, sensor_go, inv_flag, sel_flag, crc_err
  );
endinterface

// File: rtl/tag_inventory_ctrl.sv
// Gen2 tag state machine: acts once per rising edge of packet_complete, tracks Q/slot/handle,
// and raises single-cycle reply, RNG-advance, sensor and CRC-drop pulses one clock later.
module tag_inventory_ctrl #(
  parameter int SLOT_W  = 15,
  parameter int NUM_CMD = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  tag_inventory_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {READY = 3'd0, ARBITRATE = 3'd1, REPLY = 3'd2,
                            ACKNOWLEDGED = 3'd3, OPEN = 3'd4} state_t;
  typedef enum logic [2:0] {RT_NONE = 3'd0, RT_RN16 = 3'd1, RT_EPC = 3'd2,
                            RT_HANDLE = 3'd3, RT_DATA = 3'd4} reply_t;

  localparam logic [SLOT_W:0]   ONE_M = 1;
  localparam logic [SLOT_W-1:0] ONE_S = 1;
  localparam logic [NUM_CMD-1:0] ONE_C = 1;

  state_t            state_q, state_d;
  reply_t            rtype_q, rtype_d;
  logic [3:0]        q_q, q_d, q_new;
  logic [SLOT_W-1:0] slot_q, slot_d, slot_dec, draw_slot;
  logic [SLOT_W:0]   mask;
  logic [15:0]       rn16_q, rn16_d, handle_q, handle_d;
  logic              inv_q, inv_d, sel_q, sel_d, pc_q;
  logic              go_q, go_d, sensor_q, sensor_d, rng_q, rng_d, crc_q, crc_d;
  logic              evt, crc_drop;
  logic [NUM_CMD-1:0] c;

  // State register: everything, including the pulses, clears asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= READY;   rtype_q  <= RT_NONE;
      q_q     <= '0;      slot_q   <= '0;
      rn16_q  <= '0;      handle_q <= '0;
      inv_q   <= 1'b0;    sel_q    <= 1'b0;   pc_q  <= 1'b0;
      go_q    <= 1'b0;    sensor_q <= 1'b0;   rng_q <= 1'b0;  crc_q <= 1'b0;
    end else begin
      state_q <= state_d; rtype_q  <= rtype_d;
      q_q     <= q_d;     slot_q   <= slot_d;
      rn16_q  <= rn16_d;  handle_q <= handle_d;
      inv_q   <= inv_d;   sel_q    <= sel_d;  pc_q  <= bus.packet_complete;
      go_q    <= go_d;    sensor_q <= sensor_d; rng_q <= rng_d; crc_q <= crc_d;
    end
  end

  // Lowest set command bit wins; CRC check applies to the winning command only.
  assign evt      = bus.packet_complete & ~pc_q;
  assign c        = bus.cmd & (~bus.cmd + ONE_C);
  assign crc_drop = (c[2] & bus.crc5invalid) |
                    ((c[4] | c[6] | c[7] | c[8] | c[11]) & bus.crc16invalid);

  always_comb begin
    q_new = q_q;
    if (c[2])                                    q_new = bus.q_in;
    else if (bus.updn == 3'b110 && q_q != 4'hF)  q_new = q_q + 4'd1;
    else if (bus.updn == 3'b011 && q_q != 4'h0)  q_new = q_q - 4'd1;
  end

  assign mask      = (ONE_M << q_new) - ONE_M;
  assign draw_slot = bus.rn_in[SLOT_W-1:0] & mask[SLOT_W-1:0];
  assign slot_dec  = slot_q - ONE_S;

  // Next-state process
  always_comb begin
    state_d = state_q;  rtype_d  = rtype_q;
    q_d     = q_q;      slot_d   = slot_q;
    rn16_d  = rn16_q;   handle_d = handle_q;
    inv_d   = inv_q;    sel_d    = sel_q;
    go_d    = 1'b0;     sensor_d = 1'b0;  rng_d = 1'b0;  crc_d = 1'b0;
    if (evt) begin
      if (crc_drop) begin
        crc_d = 1'b1;
      end else if (c[0]) begin
        case (state_q)
          ARBITRATE: begin
            slot_d = slot_dec;
            if (slot_dec == '0) begin
              rn16_d = bus.rn_in; rng_d = 1'b1; state_d = REPLY; go_d = 1'b1; rtype_d = RT_RN16;
            end
          end
          REPLY:              state_d = ARBITRATE;
          ACKNOWLEDGED, OPEN: begin state_d = READY; inv_d = ~inv_q; end
          default: ;
        endcase
      end else if (c[1]) begin
        if (bus.rn_match && state_q inside {REPLY, ACKNOWLEDGED, OPEN}) begin
          state_d = ACKNOWLEDGED; go_d = 1'b1; rtype_d = RT_EPC;
        end else if (state_q == REPLY) begin
          state_d = ARBITRATE;
        end
      end else if (c[2] || (c[3] && state_q != READY)) begin
        q_d = q_new; slot_d = draw_slot; rn16_d = bus.rn_in; rng_d = 1'b1;
        if (draw_slot == '0) begin
          state_d = REPLY; go_d = 1'b1; rtype_d = RT_RN16;
        end else begin
          state_d = ARBITRATE;
        end
      end else if (c[4]) begin
        state_d = READY; sel_d = bus.select_match;
      end else if (c[5]) begin
        if (state_q != READY) state_d = ARBITRATE;
      end else if (c[6]) begin
        if (bus.rn_match && state_q == ACKNOWLEDGED) begin
          handle_d = bus.rn_in; rng_d = 1'b1; state_d = OPEN; go_d = 1'b1; rtype_d = RT_HANDLE;
        end else if (bus.rn_match && state_q == OPEN) begin
          rn16_d = bus.rn_in; rng_d = 1'b1; go_d = 1'b1; rtype_d = RT_RN16;
        end
      end else if (|c[12:7]) begin
        if (bus.rn_match && state_q == OPEN) begin
          go_d = 1'b1; rtype_d = RT_DATA; sensor_d = c[10];
        end
      end
    end
  end

  // Output process
  always_comb begin
    bus.state      = state_q;
    bus.reply_type = rtype_q;
    bus.q_cur      = q_q;
    bus.slot       = slot_q;
    bus.rn16       = rn16_q;
    bus.handle     = handle_q;
    bus.inv_flag   = inv_q;
    bus.sel_flag   = sel_q;
    bus.reply_go   = go_q;
    bus.sensor_go  = sensor_q;
    bus.rng_next   = rng_q;
    bus.crc_err    = crc_q;
  end
endmodule

// File: tb/tb_tag_inventory_ctrl.sv
// Directed plus random command stream against a behavioural model of the Gen2 tag rules.
module tb_tag_inventory_ctrl;
  localparam int SLOT_W = 15;
  localparam int NSLOT  = 1 << SLOT_W;
  localparam int S_READY = 0, S_ARB = 1, S_REPLY = 2, S_ACK = 3, S_OPEN = 4;
  localparam int R_NONE = 0, R_RN16 = 1, R_EPC = 2, R_HANDLE = 3, R_DATA = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  tag_inventory_ctrl_if #(.SLOT_W(SLOT_W), .NUM_CMD(13)) bus ();
  tag_inventory_ctrl #(.SLOT_W(SLOT_W), .NUM_CMD(13)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference model state
  int m_state, m_q, m_slot, m_rn16, m_handle, m_rtype, m_inv, m_sel;
  int e_go, e_sen, e_rng, e_crc;

  task automatic model_reset();
    m_state = S_READY; m_q = 0; m_slot = 0; m_rn16 = 0; m_handle = 0;
    m_rtype = R_NONE;  m_inv = 0; m_sel = 0;
    e_go = 0; e_sen = 0; e_rng = 0; e_crc = 0;
  endtask

  task automatic reply(input int t);
    e_go = 1; m_rtype = t;
  endtask

  task automatic draw(input int q, input int rn);
    m_q = q; m_slot = rn % (1 << q); m_rn16 = rn; e_rng = 1;
    if (m_slot == 0) begin m_state = S_REPLY; reply(R_RN16); end
    else m_state = S_ARB;
  endtask

  task automatic model_step(input logic [12:0] cv, input bit c5, input bit c16, input int qi,
                            input int ud, input int rn, input bit rm, input bit sm);
    int k = -1;
    int nq;
    e_go = 0; e_sen = 0; e_rng = 0; e_crc = 0;
    for (int i = 12; i >= 0; i--) if (cv[i]) k = i;
    if (k < 0) return;
    if ((k == 2 && c5) || ((k == 4 || k == 6 || k == 7 || k == 8 || k == 11) && c16)) begin
      e_crc = 1; return;
    end
    case (k)
      0: begin
        if (m_state == S_ARB) begin
          m_slot = (m_slot + NSLOT - 1) % NSLOT;
          if (m_slot == 0) begin m_rn16 = rn; e_rng = 1; m_state = S_REPLY; reply(R_RN16); end
        end else if (m_state == S_REPLY) m_state = S_ARB;
        else if (m_state == S_ACK || m_state == S_OPEN) begin m_state = S_READY; m_inv = 1 - m_inv; end
      end
      1: begin
        if (rm && m_state >= S_REPLY) begin m_state = S_ACK; reply(R_EPC); end
        else if (m_state == S_REPLY) m_state = S_ARB;
      end
      2: draw(qi, rn);
      3: if (m_state != S_READY) begin
        nq = m_q;
        if (ud == 6) nq = (m_q == 15) ? 15 : m_q + 1;
        else if (ud == 3) nq = (m_q == 0) ? 0 : m_q - 1;
        draw(nq, rn);
      end
      4: begin m_state = S_READY; m_sel = sm; end
      5: if (m_state != S_READY) m_state = S_ARB;
      6: begin
        if (rm && m_state == S_ACK) begin m_handle = rn; e_rng = 1; m_state = S_OPEN; reply(R_HANDLE); end
        else if (rm && m_state == S_OPEN) begin m_rn16 = rn; e_rng = 1; reply(R_RN16); end
      end
      default: if (rm && m_state == S_OPEN) begin reply(R_DATA); e_sen = (k == 10) ? 1 : 0; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string p);
    chk({p, ".state"},      32'(bus.state),      32'(m_state));
    chk({p, ".q_cur"},      32'(bus.q_cur),      32'(m_q));
    chk({p, ".slot"},       32'(bus.slot),       32'(m_slot));
    chk({p, ".rn16"},       32'(bus.rn16),       32'(m_rn16));
    chk({p, ".handle"},     32'(bus.handle),     32'(m_handle));
    chk({p, ".reply_type"}, 32'(bus.reply_type), 32'(m_rtype));
    chk({p, ".inv_flag"},   32'(bus.inv_flag),   32'(m_inv));
    chk({p, ".sel_flag"},   32'(bus.sel_flag),   32'(m_sel));
    chk({p, ".reply_go"},   32'(bus.reply_go),   32'(e_go));
    chk({p, ".sensor_go"},  32'(bus.sensor_go),  32'(e_sen));
    chk({p, ".rng_next"},   32'(bus.rng_next),   32'(e_rng));
    chk({p, ".crc_err"},    32'(bus.crc_err),    32'(e_crc));
  endtask

  task automatic drive(input logic [12:0] cv, input bit c5, input bit c16, input logic [3:0] qi,
                       input logic [2:0] ud, input logic [15:0] rn, input bit rm, input bit sm);
    bus.cmd = cv; bus.crc5invalid = c5; bus.crc16invalid = c16; bus.q_in = qi;
    bus.updn = ud; bus.rn_in = rn; bus.rn_match = rm; bus.select_match = sm;
  endtask

  // One full command: event edge, check, drop packet_complete, check idle cycle.
  task automatic send(input string p, input logic [12:0] cv, input bit c5, input bit c16,
                      input logic [3:0] qi, input logic [2:0] ud, input logic [15:0] rn,
                      input bit rm, input bit sm);
    @(negedge clk);
    drive(cv, c5, c16, qi, ud, rn, rm, sm);
    bus.packet_complete = 1'b1;
    @(posedge clk); #1;
    model_step(cv, c5, c16, int'(qi), int'(ud), int'(rn), rm, sm);
    check_all(p);
    @(negedge clk);
    bus.packet_complete = 1'b0;
    drive(13'd0, 1'b0, 1'b0, 4'd0, 3'd0, 16'hFFFF, 1'b1, 1'b1);
    @(posedge clk); #1;
    e_go = 0; e_sen = 0; e_rng = 0; e_crc = 0;
    check_all({p, "_idle"});
  endtask

  function automatic logic [12:0] cb(input int i);
    logic [12:0] one = 13'd1;
    return one << i;
  endfunction

  initial begin
    int cnt;
    int idx;
    logic [12:0] cv;
    logic [15:0] rn;
    logic [3:0] qi;
    bus.packet_complete = 1'b0;
    drive(13'd0, 1'b0, 1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk); reset = 1'b1;

    // Query with Q=0 replies immediately
    send("t1_query", cb(2), 0, 0, 4'd0, 3'd0, 16'hBEEF, 0, 0);
    chk("t1_rn16_const", 32'(bus.rn16), 32'hBEEF);

    // Count down through slots, then wrap from zero
    send("t2_query", cb(2), 0, 0, 4'd2, 3'd0, 16'h0003, 0, 0);
    chk("t2_slot3", 32'(bus.slot), 32'd3);
    send("t2_rep1", cb(0), 0, 0, 4'd0, 3'd0, 16'h0000, 0, 0);
    send("t2_rep2", cb(0), 0, 0, 4'd0, 3'd0, 16'h0000, 0, 0);
    send("t2_rep3", cb(0), 0, 0, 4'd0, 3'd0, 16'h1234, 0, 0);
    chk("t2_reply_state", 32'(bus.state), 32'd2);
    send("t2_rep4", cb(0), 0, 0, 4'd0, 3'd0, 16'h0000, 0, 0);
    send("t2_wrap", cb(0), 0, 0, 4'd0, 3'd0, 16'h0000, 0, 0);
    chk("t2_wrap_const", 32'(bus.slot), 32'h7FFF);

    // Full access handshake plus CRC drops
    send("t3_query", cb(2), 0, 0, 4'd0, 3'd0, 16'h5555, 0, 0);
    send("t3_ack",   cb(1), 0, 0, 4'd0, 3'd0, 16'h0000, 1, 0);
    send("t3_reqrn", cb(6), 0, 0, 4'd0, 3'd0, 16'hA5A5, 1, 0);
    chk("t3_handle_const", 32'(bus.handle), 32'hA5A5);
    send("t3_sample", cb(10), 0, 0, 4'd0, 3'd0, 16'h0000, 1, 0);
    send("t4_read_crc", cb(7), 0, 1, 4'd0, 3'd0, 16'h0000, 1, 0);
    send("t4_query_crc", cb(2), 1, 0, 4'd3, 3'd0, 16'h0001, 0, 0);
    send("t3_rep_inv", cb(0), 0, 0, 4'd0, 3'd0, 16'h0000, 0, 0);
    chk("t3_inv_const", 32'(bus.inv_flag), 32'd1);

    // QueryAdj ignored in READY, then saturation at both ends
    send("t5_adj_ready", cb(3), 0, 0, 4'd0, 3'd6, 16'h0000, 0, 0);
    send("t5_q15", cb(2), 0, 0, 4'd15, 3'd0, 16'h8001, 0, 0);
    send("t5_adj_up", cb(3), 0, 0, 4'd0, 3'd6, 16'h1234, 0, 0);
    chk("t5_q15_const", 32'(bus.q_cur), 32'd15);
    send("t5_q0", cb(2), 0, 0, 4'd0, 3'd0, 16'h0F0F, 0, 0);
    send("t5_adj_dn", cb(3), 0, 0, 4'd0, 3'd3, 16'h7777, 0, 0);
    send("t5_multi", cb(0) | cb(2) | cb(5), 0, 0, 4'd4, 3'd0, 16'h0000, 0, 0);
    send("t5_select", cb(4), 0, 0, 4'd0, 3'd0, 16'h0000, 0, 1);

    // packet_complete held high: exactly one event
    cnt = 0;
    @(negedge clk);
    drive(cb(2), 0, 0, 4'd0, 3'd0, 16'h4242, 0, 0);
    bus.packet_complete = 1'b1;
    model_step(cb(2), 0, 0, 0, 0, 16'h4242, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cnt += int'(bus.rng_next);
    end
    chk("t6_held_events", 32'(cnt), 32'd1);
    e_go = 0; e_rng = 0;
    check_all("t6_held");
    @(negedge clk); bus.packet_complete = 1'b0;
    @(negedge clk);

    // Asynchronous reset right after an event kills the pulse in flight
    drive(cb(2), 0, 0, 4'd0, 3'd0, 16'h1111, 0, 0);
    bus.packet_complete = 1'b1;
    @(posedge clk); #1;
    chk("t6_go_before_rst", 32'(bus.reply_go), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t6_go_in_rst", 32'(bus.reply_go), 32'd0);
    chk("t6_state_in_rst", 32'(bus.state), 32'd0);
    model_reset();
    check_all("t6_rst");
    @(negedge clk);
    bus.packet_complete = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // Random command stream
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 5) begin
        case ($urandom_range(0, 3))
          0: idx = 0;
          1: idx = 1;
          2: idx = 2;
          default: idx = 6;
        endcase
      end else idx = $urandom_range(0, 12);
      cv = cb(idx);
      if ($urandom_range(0, 5) == 0) cv = cv | 13'($urandom);
      if ($urandom_range(0, 15) == 0) cv = 13'd0;
      qi = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      rn = 16'($urandom);
      send("rnd", cv, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, qi,
           3'($urandom_range(0, 7)), rn, $urandom_range(0, 4) != 0, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
